// File: rtl/buzzer_io_pkg.sv
// rtl/buzzer_io_pkg.sv - shared types and register map for the buzzer I/O hub
package buzzer_io_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_DECIDED = 2'd2,
        ST_TIMEOUT = 2'd3
    } state_t;

    // Register offsets from IO_BASE
    localparam logic [2:0] REG_STATUS  = 3'd0;
    localparam logic [2:0] REG_CONTROL = 3'd1;
    localparam logic [2:0] REG_SWITCH  = 3'd2;
    localparam logic [2:0] REG_PRESS   = 3'd3;
    localparam logic [2:0] REG_TIMEOUT = 3'd4;
    localparam logic [2:0] REG_LOCKOUT = 3'd5;

    // CONTROL bit positions
    localparam int CTRL_START  = 0;
    localparam int CTRL_CLEAR  = 1;
    localparam int CTRL_LOCKEN = 2;

    // STATUS bit positions; first_player occupies [7:4]
    localparam int STAT_ACTIVE     = 0;
    localparam int STAT_VALID      = 1;
    localparam int STAT_TIMEOUT    = 2;
    localparam int STAT_PLAYER_LSB = 4;

endpackage

// File: rtl/buzzer_io_hub_debounce.sv
// rtl/buzzer_io_hub_debounce.sv - single-bit debouncer with rising-edge pulse
module debounce_chan #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic in,
    output logic level,
    output logic rise
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic [CW-1:0] cnt;

    // Count consecutive samples that disagree with the level; flip after a full run.
    // rise is registered alongside level so it is high in the first cycle the level is 1.
    always_ff @(posedge clk) begin
        if (rst) begin
            level <= 1'b0;
            rise  <= 1'b0;
            cnt   <= '0;
        end else begin
            rise <= 1'b0;
            if (in == level) begin
                cnt <= '0;
            end else if (cnt == CNT_MAX) begin
                level <= in;
                rise  <= in;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/buzzer_io_hub.sv
// rtl/buzzer_io_hub.sv - debounced buzzer arbitration with memory-mapped registers
module buzzer_io_hub
    import buzzer_io_pkg::*;
#(
    parameter int          NUM_PLAYERS     = 4,
    parameter int          SW_WIDTH        = 8,
    parameter int          DEBOUNCE_CYCLES = 16,
    parameter int          TIMER_WIDTH     = 16,
    parameter logic [15:0] IO_BASE         = 16'hC000,
    localparam int         PW              = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_PLAYERS-1:0] btn_raw,
    input  logic [SW_WIDTH-1:0]    sw_raw,
    input  logic [15:0]            adr,
    input  logic [15:0]            writedata,
    input  logic                   memwrite,
    input  logic                   memread,
    output logic                   io_sel,
    output logic [15:0]            rdata,
    output logic                   round_active,
    output logic                   first_valid,
    output logic [PW-1:0]          first_player,
    output logic                   timed_out,
    output logic [NUM_PLAYERS-1:0] press_mask
);

    state_t                   state;
    logic [TIMER_WIDTH-1:0]   timer;
    logic [TIMER_WIDTH-1:0]   timeout_reg;
    logic [NUM_PLAYERS-1:0]   lockout;
    logic                     lockout_en;

    logic [NUM_PLAYERS-1:0]   btn_level;
    logic [NUM_PLAYERS-1:0]   btn_rise;
    logic [SW_WIDTH-1:0]      sw_level;
    logic [SW_WIDTH-1:0]      sw_rise;

    logic [15:0]              adr_off;
    logic [2:0]               off;
    logic                     wr;
    logic                     rd;
    logic                     start;
    logic                     clear;
    logic [NUM_PLAYERS-1:0]   w1c;
    logic [NUM_PLAYERS-1:0]   btn_evt;
    logic [NUM_PLAYERS-1:0]   elig;
    logic [NUM_PLAYERS-1:0]   press_keep;
    logic [PW-1:0]            win;
    logic [15:0]              status;
    logic [15:0]              rd_mux;
    logic                     unused_bits;

    // Buttons are active-low; invert so the debouncer's reset level means "released"
    for (genvar i = 0; i < NUM_PLAYERS; i++) begin : g_btn
        debounce_chan #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
            .clk   (clk),
            .rst   (rst),
            .in    (~btn_raw[i]),
            .level (btn_level[i]),
            .rise  (btn_rise[i])
        );
    end

    for (genvar i = 0; i < SW_WIDTH; i++) begin : g_sw
        debounce_chan #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
            .clk   (clk),
            .rst   (rst),
            .in    (sw_raw[i]),
            .level (sw_level[i]),
            .rise  (sw_rise[i])
        );
    end

    assign io_sel  = (adr >= IO_BASE) && (adr <= IO_BASE + 16'd7);
    assign adr_off = adr - IO_BASE;
    assign off     = adr_off[2:0];
    assign wr      = memwrite && io_sel;
    assign rd      = memread && io_sel;
    assign start   = wr && (off == REG_CONTROL) && writedata[CTRL_START];
    assign clear   = wr && (off == REG_CONTROL) && writedata[CTRL_CLEAR];
    assign w1c     = (wr && (off == REG_PRESS)) ? writedata[NUM_PLAYERS-1:0] : '0;

    // rise already implies the level is pressed; the AND keeps btn_level meaningful
    assign btn_evt    = btn_rise & btn_level;
    assign elig       = btn_evt & ~lockout;
    assign press_keep = press_mask & ~w1c;

    assign round_active = (state == ST_ARMED);
    assign first_valid  = (state == ST_DECIDED);
    assign timed_out    = (state == ST_TIMEOUT);

    assign unused_bits = ^{sw_rise, adr_off[15:3]};

    // Lowest eligible index: scan downward so the smallest set bit is assigned last
    always_comb begin
        win = '0;
        for (int i = NUM_PLAYERS - 1; i >= 0; i--) begin
            if (elig[i]) win = PW'(i);
        end
    end

    // Status word and read-data selection
    always_comb begin
        status = '0;
        status[STAT_ACTIVE]  = round_active;
        status[STAT_VALID]   = first_valid;
        status[STAT_TIMEOUT] = timed_out;
        status[STAT_PLAYER_LSB +: 4] = 4'(first_player);
        rd_mux = '0;
        case (off)
            REG_STATUS:  rd_mux = status;
            REG_SWITCH:  rd_mux = 16'(sw_level);
            REG_PRESS:   rd_mux = 16'(press_mask);
            REG_TIMEOUT: rd_mux = 16'(timeout_reg);
            REG_LOCKOUT: rd_mux = 16'(lockout);
            default:     rd_mux = '0;
        endcase
    end

    // Bus-side registers: timeout reload, lockout enable and registered read data
    always_ff @(posedge clk) begin
        if (rst) begin
            timeout_reg <= '0;
            lockout_en  <= 1'b0;
            rdata       <= '0;
        end else begin
            if (wr && (off == REG_TIMEOUT)) timeout_reg <= TIMER_WIDTH'(writedata);
            if (wr && (off == REG_CONTROL)) lockout_en  <= writedata[CTRL_LOCKEN];
            if (rd) rdata <= rd_mux;
        end
    end

    // Round state machine; a press-mask W1C is applied first so a same-cycle press wins
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            timer        <= '0;
            first_player <= '0;
            press_mask   <= '0;
            lockout      <= '0;
        end else begin
            press_mask <= press_keep;
            case (state)
                ST_IDLE: begin
                    if (clear) begin
                        lockout <= '0;
                    end else if (start) begin
                        state      <= ST_ARMED;
                        timer      <= timeout_reg;
                        press_mask <= '0;
                    end else if (lockout_en) begin
                        lockout <= lockout | btn_evt;
                    end
                end
                ST_ARMED: begin
                    if (clear) begin
                        state        <= ST_IDLE;
                        lockout      <= '0;
                        first_player <= '0;
                    end else begin
                        press_mask <= press_keep | btn_evt;
                        if (elig != '0) begin
                            state        <= ST_DECIDED;
                            first_player <= win;
                        end else if (timer == TIMER_WIDTH'(1)) begin
                            state <= ST_TIMEOUT;
                            timer <= '0;
                        end else if (timer != '0) begin
                            timer <= timer - 1'b1;
                        end
                    end
                end
                ST_DECIDED: begin
                    if (clear) begin
                        state        <= ST_IDLE;
                        lockout      <= '0;
                        first_player <= '0;
                    end else begin
                        press_mask <= press_keep | btn_evt;
                    end
                end
                ST_TIMEOUT: begin
                    if (clear) begin
                        state        <= ST_IDLE;
                        lockout      <= '0;
                        first_player <= '0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_buzzer_io_hub.sv
// tb/tb_buzzer_io_hub.sv - self-checking bench for buzzer_io_hub
module tb_buzzer_io_hub;
    import buzzer_io_pkg::*;

    localparam int NP = 4;
    localparam int SW = 8;
    localparam int DB = 16;
    localparam int PW = 2;
    localparam logic [15:0] BASE = 16'hC000;

    logic          clk = 1'b0;
    logic          rst;
    logic [NP-1:0] btn_raw;
    logic [SW-1:0] sw_raw;
    logic [15:0]   adr;
    logic [15:0]   writedata;
    logic          memwrite;
    logic          memread;
    logic          io_sel;
    logic [15:0]   rdata;
    logic          round_active;
    logic          first_valid;
    logic [PW-1:0] first_player;
    logic          timed_out;
    logic [NP-1:0] press_mask;

    int compared   = 0;
    int mismatched = 0;

    typedef struct {
        logic [15:0] val;
        string       name;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        logic        wr;
        logic [2:0]  off;
        logic [15:0] data;
        logic [15:0] exp;
        string       name;
    } vec_t;
    vec_t vt[12];

    typedef struct {
        logic [15:0] a;
        logic        sel;
    } sel_t;
    sel_t st[5];

    buzzer_io_hub #(
        .NUM_PLAYERS(NP), .SW_WIDTH(SW), .DEBOUNCE_CYCLES(DB),
        .TIMER_WIDTH(16), .IO_BASE(BASE)
    ) dut (
        .clk(clk), .rst(rst), .btn_raw(btn_raw), .sw_raw(sw_raw),
        .adr(adr), .writedata(writedata), .memwrite(memwrite), .memread(memread),
        .io_sel(io_sel), .rdata(rdata), .round_active(round_active),
        .first_valid(first_valid), .first_player(first_player),
        .timed_out(timed_out), .press_mask(press_mask)
    );

    always #5 clk = ~clk;

    initial begin
        #500us;
        $display("FAIL watchdog: simulation time limit reached, act=running req=finished");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic raw_write(input logic [15:0] a, input logic [15:0] d);
        adr = a; writedata = d; memwrite = 1'b1;
        cyc(1);
        memwrite = 1'b0;
    endtask

    task automatic bus_write(input logic [2:0] off, input logic [15:0] d);
        raw_write(BASE + 16'(off), d);
    endtask

    // Expected value is queued as the read is issued, retired when rdata updates
    task automatic bus_read(input logic [2:0] off, input logic [15:0] exp, input string name);
        exp_t e;
        adr = BASE + 16'(off); memread = 1'b1;
        sb.push_back('{exp, name});
        cyc(1);
        memread = 1'b0;
        e = sb.pop_front();
        check(e.name, 32'(rdata), 32'(e.val));
    endtask

    task automatic press(input int p);
        btn_raw[p] = 1'b0;
        cyc(DB + 1);
    endtask

    task automatic release_btn(input int p);
        btn_raw[p] = 1'b1;
        cyc(DB + 1);
    endtask

    initial begin
        int  k;
        logic seen;

        vt[0]  = '{1'b1, REG_TIMEOUT, 16'h1234, 16'h0000, "tmo_wr"};
        vt[1]  = '{1'b0, REG_TIMEOUT, 16'h0000, 16'h1234, "tmo_rd"};
        vt[2]  = '{1'b1, 3'd6,        16'hFFFF, 16'h0000, "r6_wr"};
        vt[3]  = '{1'b0, 3'd6,        16'h0000, 16'h0000, "r6_rd"};
        vt[4]  = '{1'b0, 3'd7,        16'h0000, 16'h0000, "r7_rd"};
        vt[5]  = '{1'b0, REG_STATUS,  16'h0000, 16'h0000, "status_idle"};
        vt[6]  = '{1'b0, REG_LOCKOUT, 16'h0000, 16'h0000, "lockout_idle"};
        vt[7]  = '{1'b0, REG_PRESS,   16'h0000, 16'h0000, "press_idle"};
        vt[8]  = '{1'b1, REG_STATUS,  16'hFFFF, 16'h0000, "status_wr"};
        vt[9]  = '{1'b0, REG_STATUS,  16'h0000, 16'h0000, "status_ro"};
        vt[10] = '{1'b1, REG_TIMEOUT, 16'h0000, 16'h0000, "tmo_wr0"};
        vt[11] = '{1'b0, REG_TIMEOUT, 16'h0000, 16'h0000, "tmo_rd0"};

        st[0] = '{16'hC000, 1'b1};
        st[1] = '{16'hC007, 1'b1};
        st[2] = '{16'hBFFF, 1'b0};
        st[3] = '{16'hC008, 1'b0};
        st[4] = '{16'h0003, 1'b0};

        rst = 1'b1; btn_raw = '1; sw_raw = 8'hA5;
        adr = '0; writedata = '0; memwrite = 1'b0; memread = 1'b0;
        cyc(2);
        check("rst_rdata", 32'(rdata), 0);
        check("rst_outputs", {27'b0, round_active, first_valid, timed_out, first_player},
              0);
        check("rst_press_mask", 32'(press_mask), 0);
        rst = 1'b0;

        // Switches not yet settled right after reset
        bus_read(REG_SWITCH, 16'h0000, "switch_unsettled");

        for (int i = 0; i < 5; i++) begin
            adr = st[i].a;
            #1;
            check($sformatf("io_sel_%04h", st[i].a), 32'(io_sel), 32'(st[i].sel));
        end

        cyc(DB + 4);
        bus_read(REG_SWITCH, 16'h00A5, "switch_settled");

        for (int i = 0; i < 12; i++) begin
            if (vt[i].wr) bus_write(vt[i].off, vt[i].data);
            else          bus_read(vt[i].off, vt[i].exp, vt[i].name);
        end

        // rdata holds without a read strobe
        adr = BASE + 16'(REG_SWITCH);
        cyc(3);
        check("rdata_hold", 32'(rdata), 0);

        // Write outside the I/O window must not start a round
        raw_write(16'hC009, 16'h0001);
        check("outside_write", 32'(round_active), 0);

        // start+clear together: clear wins
        bus_write(REG_CONTROL, 16'h0003);
        check("start_clear", 32'(round_active), 0);

        // Debounce: bounce player 2, then hold pressed
        bus_write(REG_CONTROL, 16'h0001);
        seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            btn_raw[2] = ((i / 3) % 2 == 0) ? 1'b0 : 1'b1;
            cyc(1);
            if (first_valid) seen = 1'b1;
        end
        check("bounce_no_event", 32'(seen), 0);
        btn_raw[2] = 1'b0;
        k = 0;
        for (int i = 1; i <= 40; i++) begin
            cyc(1);
            if (first_valid) begin k = i; break; end
        end
        check("debounce_latency", k, DB + 1);
        check("debounce_winner", 32'(first_player), 2);
        bus_read(REG_PRESS, 16'h0004, "debounce_press");
        bus_write(REG_CONTROL, 16'h0002);
        release_btn(2);

        // Basic round
        bus_write(REG_CONTROL, 16'h0001);
        check("armed", 32'(round_active), 1);
        press(3);
        bus_read(REG_STATUS, 16'h0032, "status_decided");
        check("basic_first_player", 32'(first_player), 3);
        check("basic_first_valid", 32'(first_valid), 1);
        release_btn(3);
        press(0);
        check("late_press_no_change", 32'(first_player), 3);
        bus_read(REG_PRESS, 16'h0009, "press_decided");
        bus_write(REG_PRESS, 16'h0008);
        bus_read(REG_PRESS, 16'h0001, "press_w1c");
        bus_write(REG_CONTROL, 16'h0002);
        bus_read(REG_STATUS, 16'h0000, "status_cleared");
        release_btn(0);

        // Tie between players 1 and 2
        bus_write(REG_CONTROL, 16'h0001);
        btn_raw[1] = 1'b0; btn_raw[2] = 1'b0;
        cyc(DB + 1);
        check("tie_winner", 32'(first_player), 1);
        bus_read(REG_PRESS, 16'h0006, "tie_press");
        bus_write(REG_CONTROL, 16'h0002);
        btn_raw[1] = 1'b1; btn_raw[2] = 1'b1;
        cyc(DB + 1);

        // Timeout with no presses
        bus_write(REG_TIMEOUT, 16'd100);
        bus_write(REG_CONTROL, 16'h0001);
        k = 0;
        for (int i = 1; i <= 150; i++) begin
            cyc(1);
            if (timed_out) begin k = i; break; end
        end
        check("timeout_latency", k, 100);
        check("timeout_no_winner", 32'(first_valid), 0);
        bus_write(REG_CONTROL, 16'h0002);

        // Press landing on the expiry cycle wins
        bus_write(REG_CONTROL, 16'h0001);
        cyc(83);
        btn_raw[0] = 1'b0;
        cyc(DB);
        check("expiry_still_armed", 32'(round_active), 1);
        cyc(1);
        check("expiry_press_wins", {30'b0, first_valid, timed_out}, 32'h2);
        check("expiry_winner", 32'(first_player), 0);
        bus_write(REG_CONTROL, 16'h0002);
        release_btn(0);
        bus_write(REG_TIMEOUT, 16'd0);

        // False-start lockout
        bus_write(REG_CONTROL, 16'h0004);
        press(0);
        bus_read(REG_LOCKOUT, 16'h0001, "lockout_set");
        release_btn(0);
        bus_write(REG_CONTROL, 16'h0001);
        press(0);
        check("locked_press_ignored", 32'(round_active), 1);
        press(2);
        check("lockout_winner", 32'(first_player), 2);
        bus_write(REG_CONTROL, 16'h0002);
        bus_read(REG_LOCKOUT, 16'h0000, "lockout_cleared");
        btn_raw[0] = 1'b1; btn_raw[2] = 1'b1;
        cyc(DB + 1);

        // Reset in the middle of a decided round
        bus_write(REG_CONTROL, 16'h0001);
        press(3);
        check("pre_reset_decided", 32'(first_valid), 1);
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        check("mid_reset_outputs",
              {22'b0, press_mask, round_active, first_valid, timed_out, first_player, rdata[0]}, 0);
        check("mid_reset_rdata", 32'(rdata), 0);
        bus_read(REG_SWITCH, 16'h0000, "switch_after_reset");
        cyc(DB + 4);
        bus_read(REG_SWITCH, 16'h00A5, "switch_resettled");
        release_btn(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/buzzer_io_hub.md
Name: buzzer_io_hub

Overview:
Parametrised successor to the fixed four-player controller and I/O-space decode. It debounces N player buttons and the board switch bank and arbitrates first-press per round with a round state machine, timeout and false-start lockout. It exposes status and control as memory-mapped registers in I/O space above IO_BASE. It sits beside exmem on the CPU address/data bus and drives the VGA and game-status logic.

Parameters:
NUM_PLAYERS, 4, number of buzzer channels (2..16)
SW_WIDTH, 8, board switch bits sampled
DEBOUNCE_CYCLES, 16, consecutive stable cycles before a debounced level changes (>=2)
TIMER_WIDTH, 16, width of round timeout counter
IO_BASE, 16'hC000, word address of register 0

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
btn_raw  in  NUM_PLAYERS  raw buttons, active-low (GPIO pulled up)
sw_raw  in  SW_WIDTH  raw switches, active-high
adr  in  16  CPU word address
writedata  in  16  CPU write data
memwrite  in  1  write strobe, one cycle
memread  in  1  read strobe, one cycle
io_sel  out  1  combinational: adr in [IO_BASE, IO_BASE+7]
rdata  out  16  registered read data
round_active  out  1  state == ARMED
first_valid  out  1  state == DECIDED
first_player  out  PW  winning channel index, PW = max(1, clog2(NUM_PLAYERS))
timed_out  out  1  state == TIMEOUT
press_mask  out  NUM_PLAYERS  sticky per-player press record for the current round

Behaviour:
- Reset clears all state and outputs to 0: state IDLE, debounced levels released, timer 0, lockout 0, rdata 0.
- Debounce, per bit: a counter restarts whenever raw != debounced level. After DEBOUNCE_CYCLES equal samples the level updates. Button press event = debounced released->pressed edge, a one-cycle pulse.
- Register map (offset from IO_BASE):
  - 0 STATUS (RO): [0] round_active, [1] first_valid, [2] timed_out, [7:4] first_player.
  - 1 CONTROL (WO): [0] start, [1] clear, [2] lockout_en.
  - 2 SWITCH (RO): debounced switches, zero-extended.
  - 3 PRESS (RO; write-1-clears bits): press_mask.
  - 4 TIMEOUT (RW): reload value, in cycles.
  - 5 LOCKOUT (RO): lockout mask.
  - 6-7: read 0, writes ignored.
- Writes: take effect on the edge where memwrite && io_sel.
- Reads: rdata updates the edge after memread && io_sel. Otherwise rdata holds its value.
- State machine: IDLE, ARMED, DECIDED, TIMEOUT.
  - IDLE -start-> ARMED: timer loaded from TIMEOUT, press_mask cleared.
  - ARMED -first eligible press-> DECIDED: first_player latched.
  - ARMED -timer reaches 0 (TIMEOUT != 0)-> TIMEOUT.
  - DECIDED or TIMEOUT -clear-> IDLE. Clear in ARMED aborts to IDLE.
  - TIMEOUT register = 0 disables the timeout.
- Eligible press: event from a channel whose lockout bit is 0.
- Presses in DECIDED: set press_mask bits only; first_player is unchanged.
- Simultaneous eligible presses in one cycle: lowest index wins. All pressing bits are set in press_mask.
- False start: a press in IDLE with lockout_en=1 sets that channel's lockout bit. Lockout bits clear on the transition out of DECIDED/TIMEOUT to IDLE, and on clear.
- Same-cycle rules:
  - start and clear together: clear wins.
  - start write and a press: the press is ignored (no lockout set).
  - timer expiry and an eligible press: the press wins (DECIDED).
  - PRESS write-1-clear and a new press on the same bit: the set wins.
- rst mid-round: returns to IDLE within one cycle. Debounce counters restart.

Decomposition:
- Package buzzer_io_pkg: state enum; register offsets REG_STATUS..REG_LOCKOUT; control bit positions CTRL_START, CTRL_CLEAR, CTRL_LOCKEN; status bit positions.
- Sub-module debounce_chan (parameter DEBOUNCE_CYCLES): one bit in, level and rise-pulse out. Instantiated NUM_PLAYERS+SW_WIDTH times.

Test Plan:
- Debounce: btn_raw[2] bounces 0/1 every 3 cycles for 30 cycles, then held 0 (pressed). No event while bouncing. One event exactly DEBOUNCE_CYCLES=16 cycles after it settles.
- Basic round: write CONTROL=1, then press player 3 -> STATUS reads 0x0032 one cycle after memread. first_player=3, first_valid=1. Write CONTROL=2 -> STATUS reads 0.
- Tie: players 1 and 2 debounce on the same cycle while ARMED -> first_player=1, PRESS reads 0x0006.
- Timeout: TIMEOUT=100, start, no presses -> timed_out rises exactly 100 cycles after the start write. A press on the expiry cycle instead gives DECIDED.
- Lockout: CONTROL=4, player 0 presses in IDLE -> LOCKOUT=0x0001. Start; player 0 presses, then player 2 -> first_player=2. After clear, LOCKOUT=0.
- Reset mid-DECIDED: assert rst for one cycle -> all outputs 0, state IDLE. SWITCH reads 0 until switches settle.
